timer_alarm: RTL and testbench

Memory-mapped compare/alarm unit that sits directly downstream of the millisecond timer. It consumes the free-running 32-bit millisecond count and raises an interrupt when the count reaches a programmed compare value, in either one-shot or periodic mode. The CPU programs and polls it through the MMIO bus, and the interrupt line feeds the core's external-interrupt input.

---
 rtl/timer_alarm.sv | 151 +++++++++++++++
 tb/tb_timer_alarm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_alarm.sv
// timer_alarm: memory-mapped compare/alarm unit driven by the free-running
// millisecond count. Fires once (one-shot) or repeatedly (periodic reload)
// when the count steps onto the programmed compare value, and raises a
// level interrupt while the pending flag is set and interrupts are enabled.
module timer_alarm #(
  parameter logic [31:0] BASE = 32'hFFFF_FF40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] timer,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_CMP    = 2'd1;
  localparam logic [1:0] OFF_PERIOD = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] prev_timer_q;
  logic [2:0]  ctrl_q, ctrl_d;       // {IE, PERIODIC, EN}
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic        pend_q, pend_d;
  logic [7:0]  miss_q, miss_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic        sel;
  logic        wr_ctrl, wr_cmp, wr_period, wr_status;
  logic        tick, fire, reload;
  logic [31:0] rd_word;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Address decode and fire detection, all based on pre-write register state.
  always_comb begin
    sel       = (addr[31:4] == BASE[31:4]);
    wr_ctrl   = we & sel & (addr[3:2] == OFF_CTRL);
    wr_cmp    = we & sel & (addr[3:2] == OFF_CMP);
    wr_period = we & sel & (addr[3:2] == OFF_PERIOD);
    wr_status = we & sel & (addr[3:2] == OFF_STATUS);
    tick      = (timer != prev_timer_q);
    fire      = (state_q == ARMED) & tick & (timer == cmp_q);
    // Periodic with a zero interval degenerates to one-shot.
    reload    = fire & ctrl_q[1] & (period_q != 32'd0);
  end

  // Read mux: selected register contents as seen before this cycle's write.
  always_comb begin
    rd_word = 32'd0;
    case (addr[3:2])
      OFF_CTRL:   rd_word = {29'd0, ctrl_q};
      OFF_CMP:    rd_word = cmp_q;
      OFF_PERIOD: rd_word = period_q;
      OFF_STATUS: rd_word = {16'd0, miss_q, 6'd0, (state_q == ARMED), pend_q};
      default:    rd_word = 32'd0;
    endcase
  end

  // Next-state computation; CPU writes override hardware updates to CTRL/CMP.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    pend_d   = pend_q;
    miss_d   = miss_q;
    rdata_d  = rdata_q;

    // Alarm bookkeeping from a fire.
    if (fire && !reload) begin
      state_d   = IDLE;
      ctrl_d[0] = 1'b0;
    end
    if (reload) begin
      cmp_d = cmp_q + period_q;
    end

    // CPU register writes.
    if (wr_ctrl) begin
      ctrl_d  = wdata[2:0];
      state_d = wdata[0] ? ARMED : IDLE;
    end
    if (wr_cmp) begin
      cmp_d = wdata;
    end
    if (wr_period) begin
      period_d = wdata;
    end

    // A fire sets PEND and beats a same-cycle W1C, which then leaves MISS alone.
    if (fire) begin
      pend_d = 1'b1;
      if (pend_q) begin
        miss_d = (miss_q == 8'hFF) ? 8'hFF : miss_q + 8'd1;
      end
    end else if (wr_status && wdata[0]) begin
      pend_d = 1'b0;
      miss_d = 8'd0;
    end

    // Read data only changes on a read strobe; unmapped reads return zero.
    if (re) begin
      rdata_d = sel ? rd_word : 32'd0;
    end

    irq_d = pend_d & ctrl_d[2];
  end

  // State registers with synchronous reset; prev_timer tracks timer in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_timer_q <= timer;
      ctrl_q       <= 3'd0;
      cmp_q        <= 32'd0;
      period_q     <= 32'd0;
      pend_q       <= 1'b0;
      miss_q       <= 8'd0;
      rdata_q      <= 32'd0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_timer_q <= timer;
      ctrl_q       <= ctrl_d;
      cmp_q        <= cmp_d;
      period_q     <= period_d;
      pend_q       <= pend_d;
      miss_q       <= miss_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Scoreboard bench for timer_alarm: stimulus pushes expected read data and
// probe values into queues; a monitor pops and compares at the falling edge.
module tb_timer_alarm;

  localparam logic [31:0] BASE     = 32'hFFFF_FF40;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_CMP    = BASE + 32'h4;
  localparam logic [31:0] A_PERIOD = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  logic        clk;
  logic        rst;
  logic [31:0] timer;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        re;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    int          kind;   // 0: irq probe, 1: rdata probe, 2: read response
    logic [31:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t pr_q[$];
  logic re_seen;
  logic probe;
  int   vectors;
  int   miscompares;

  timer_alarm #(.BASE(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .timer (timer),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .re    (re),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) re_seen <= re;

  // Monitor: read responses appear the cycle after re; probes sample in place.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    if (re_seen === 1'b1) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: got %h required nothing queued", rdata);
      end else begin
        e = rd_q.pop_front();
        if (rdata !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h required %h", e.name, rdata, e.exp);
        end else begin
          $display("ok   %s: rdata %h", e.name, rdata);
        end
      end
    end
    if (probe === 1'b1) begin
      vectors++;
      if (pr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_probe: nothing queued");
      end else begin
        e   = pr_q.pop_front();
        got = (e.kind == 0) ? {31'd0, irq} : rdata;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h required %h", e.name, got, e.exp);
        end else begin
          $display("ok   %s: %h", e.name, got);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name; e.kind = 2; e.exp = exp;
    rd_q.push_back(e);
    addr = a; re = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = exp;
    pr_q.push_back(e);
    probe = 1'b1;
    @(negedge clk); #1;
    probe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_timer(input logic [31:0] t);
    timer = t;
    @(posedge clk); #1;
  endtask

  // Timer step with a bus write in the same cycle.
  task automatic step_tw(input logic [31:0] t, input logic [31:0] a, input logic [31:0] d);
    timer = t; addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0; miscompares = 0;
    probe = 1'b0; re = 1'b0; we = 1'b0;
    addr = 32'd0; wdata = 32'd0; timer = 32'd1234; rst = 1'b1;
    idle(4);
    rst = 1'b0;

    // Reset state
    rd(A_CTRL,   32'd0, "reset_ctrl");
    rd(A_CMP,    32'd0, "reset_cmp");
    rd(A_PERIOD, 32'd0, "reset_period");
    rd(A_STATUS, 32'd0, "reset_status");
    chk(0, 32'd0, "reset_irq");
    // Static timer equal to CMP: arming must not fire
    wr(A_CMP, 32'd1234);
    wr(A_CTRL, 32'h5);
    idle(3);
    rd(A_STATUS, 32'h2, "static_match_no_fire");
    chk(0, 32'd0, "static_match_irq");
    wr(A_CTRL, 32'h0);

    // One-shot
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h5);
    set_timer(3); set_timer(4); set_timer(5);
    chk(0, 32'd1, "oneshot_irq");
    rd(A_CTRL,   32'h4, "oneshot_ctrl_en_cleared");
    rd(A_STATUS, 32'h1, "oneshot_status");
    wr(A_STATUS, 32'h1);
    chk(0, 32'd0, "oneshot_irq_cleared");
    set_timer(6); set_timer(7);
    rd(A_STATUS, 32'h0, "oneshot_no_refire");

    // Periodic with miss counting
    wr(A_CMP, 32'd10);
    wr(A_PERIOD, 32'd3);
    wr(A_CTRL, 32'h7);
    set_timer(8); set_timer(9); set_timer(10);
    rd(A_CMP,    32'd13, "periodic_cmp_13");
    rd(A_STATUS, 32'h3,  "periodic_status_1");
    set_timer(11); set_timer(12); set_timer(13);
    set_timer(14); set_timer(15); set_timer(16);
    rd(A_CMP,    32'd19,     "periodic_cmp_19");
    rd(A_STATUS, 32'h0203,   "periodic_miss_2");
    chk(0, 32'd1, "periodic_irq");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h2, "w1c_clears_pend_miss");

    // Conflict: W1C with a fire while PEND already set
    set_timer(17); set_timer(18); set_timer(19);
    set_timer(20); set_timer(21);
    step_tw(22, A_STATUS, 32'h1);
    rd(A_STATUS, 32'h0103, "w1c_vs_fire");
    // Conflict: CMP write with a periodic reload
    set_timer(23); set_timer(24);
    step_tw(25, A_CMP, 32'd100);
    rd(A_CMP,    32'd100,  "cmp_write_wins");
    rd(A_STATUS, 32'h0203, "cmp_write_fire_recorded");
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h0, "cleanup_status");

    // Wrap of the reloaded compare value
    wr(A_CMP, 32'hFFFF_FFFE);
    wr(A_PERIOD, 32'd4);
    wr(A_CTRL, 32'h3);
    set_timer(32'hFFFF_FFFD); set_timer(32'hFFFF_FFFE);
    rd(A_CMP, 32'h0000_0002, "wrap_cmp");
    chk(0, 32'd0, "wrap_irq_masked");
    rd(A_STATUS, 32'h3, "wrap_fire_1");
    wr(A_STATUS, 32'h1);
    set_timer(32'hFFFF_FFFF); set_timer(0); set_timer(1); set_timer(2);
    rd(A_STATUS, 32'h3, "wrap_fire_2");
    rd(A_CMP, 32'd6, "wrap_cmp_after_2");
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);

    // PERIODIC with PERIOD=0 acts one-shot
    set_timer(3);
    wr(A_PERIOD, 32'd0);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h7);
    set_timer(4); set_timer(5);
    rd(A_CTRL,   32'h6, "period0_ctrl");
    rd(A_CMP,    32'd5, "period0_cmp");
    rd(A_STATUS, 32'h1, "period0_status");
    chk(0, 32'd1, "period0_irq");
    wr(A_STATUS, 32'h1);

    // Conflict: CTRL write with a one-shot EN clear
    wr(A_CMP, 32'd8);
    wr(A_CTRL, 32'h5);
    set_timer(6); set_timer(7);
    step_tw(8, A_CTRL, 32'h5);
    rd(A_CTRL,   32'h5, "ctrl_write_wins");
    rd(A_STATUS, 32'h3, "ctrl_write_fire_recorded");
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);

    // Bus decode and read timing
    rd(A_CMP, 32'd8, "bus_cmp");
    rd(BASE + 32'h10, 32'd0, "bus_unmapped_above");
    rd(32'h0000_0004, 32'd0, "bus_outside_base");
    wr(32'h0000_0004, 32'd55);
    wr(BASE + 32'h14, 32'd77);
    rd(A_CMP, 32'd8, "bus_no_side_effect");
    idle(3);
    chk(1, 32'd8, "rdata_hold");

    // Mid-operation reset
    wr(A_CTRL, 32'h5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rd(A_CTRL, 32'd0, "midreset_ctrl");
    rd(A_CMP,  32'd0, "midreset_cmp");

    idle(3);
    if (rd_q.size() != 0 || pr_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover_expectations: got %0d pending required 0", rd_q.size() + pr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
